// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned NREQ    = 3;
  localparam int unsigned NREG    = 4;
  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_MEM = 1;
  localparam int unsigned REQ_IO  = 2;

  typedef logic [1:0] req_idx_t;
  typedef logic [1:0] reg_idx_t;

  // Next requester index in round-robin order, wrapping IO back to ALU.
  function automatic req_idx_t rr_next(input req_idx_t idx);
    return (idx == req_idx_t'(REQ_IO)) ? req_idx_t'(REQ_ALU) : idx + 2'd1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Requester-side and register-file-side signals of the write-back arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DW = 8
);
  import regfile_wb_arbiter_pkg::*;

  logic [NREQ-1:0] req;
  logic [1:0]      dest0;
  logic [1:0]      dest1;
  logic [1:0]      dest2;
  logic [DW-1:0]   data0;
  logic [DW-1:0]   data1;
  logic [DW-1:0]   data2;
  logic [NREQ-1:0] ack;
  logic            hold;
  logic [DW-1:0]   wr_data;
  logic            load0;
  logic            load1;
  logic            load2;
  logic            load3;
  logic            wr_busy;

  modport slave (
    input  req, dest0, dest1, dest2, data0, data1, data2, hold,
    output ack, wr_data, load0, load1, load2, load3, wr_busy
  );

  modport master (
    output req, dest0, dest1, dest2, data0, data1, data2, hold,
    input  ack, wr_data, load0, load1, load2, load3, wr_busy
  );

endinterface

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: combinational one-hot grant plus priority pointer.
module rr_arbiter3
  import regfile_wb_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_i,
  input  logic            hold_i,
  output logic [NREQ-1:0] ack_o
);

  req_idx_t ptr_q, ptr_d;
  req_idx_t cand;
  req_idx_t win;
  logic     found;

  always_comb begin
    ack_o = '0;
    found = 1'b0;
    win   = ptr_q;
    cand  = ptr_q;
    if (!reset && !hold_i) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && req_i[cand]) begin
          ack_o[cand] = 1'b1;
          found       = 1'b1;
          win         = cand;
        end
        cand = rr_next(cand);
      end
    end
    // A grant always coincides with a transfer, since ack only rises on a live req.
    ptr_d = found ? rr_next(win) : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates three write requesters onto a single register-file write port,
// with a one-cycle registered write stage and dest-to-load decode.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);

  logic [NREQ-1:0] ack;
  logic            xfer;
  logic            wb_valid_q, wb_valid_d;
  reg_idx_t        wb_dest_q, wb_dest_d;
  logic [DW-1:0]   wb_data_q, wb_data_d;
  logic [NREG-1:0] load;

  rr_arbiter3 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req_i  (bus.req),
    .hold_i (bus.hold),
    .ack_o  (ack)
  );

  assign xfer = |(bus.req & ack);

  always_comb begin
    wb_valid_d = xfer;
    wb_dest_d  = wb_dest_q;
    wb_data_d  = wb_data_q;
    unique case (1'b1)
      ack[REQ_ALU]: begin
        wb_dest_d = bus.dest0;
        wb_data_d = bus.data0;
      end
      ack[REQ_MEM]: begin
        wb_dest_d = bus.dest1;
        wb_data_d = bus.data1;
      end
      ack[REQ_IO]: begin
        wb_dest_d = bus.dest2;
        wb_data_d = bus.data2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_dest_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_dest_q  <= wb_dest_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // A write still pending while reset is high is dropped, never issued.
  always_comb begin
    load = '0;
    if (wb_valid_q && !reset) begin
      load[wb_dest_q] = 1'b1;
    end
  end

  assign bus.ack     = ack;
  assign bus.wr_data = wb_data_q;
  assign bus.load0   = load[0];
  assign bus.load1   = load[1];
  assign bus.load2   = load[2];
  assign bus.load3   = load[3];
  assign bus.wr_busy = |load;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed stimulus pushes cycle-stamped
// expectations, a negedge monitor pops and compares grants and register writes.
module tb_regfile_wb_arbiter;

  typedef struct {
    int         cyc;
    logic [2:0] ack;
  } ack_exp_t;

  typedef struct {
    int         cyc;
    logic [3:0] load;
    logic [7:0] data;
  } ld_exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;

  ack_exp_t ack_q[$];
  ld_exp_t  ld_q[$];
  ack_exp_t ea;
  ld_exp_t  el;
  logic [3:0] lv;

  regfile_wb_arbiter_if #(.DW(8)) bus ();

  regfile_wb_arbiter #(.DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares whatever the DUT presents against the cycle-stamped queues.
  always @(negedge clk) begin
    lv = {bus.load3, bus.load2, bus.load1, bus.load0};

    checks++;
    if ($countones(bus.ack) > 1) begin
      failures++;
      $display("FAIL ack_onehot: cyc=%0d ack=%b, required at most one bit", cyc, bus.ack);
    end
    checks++;
    if ($countones(lv) > 1) begin
      failures++;
      $display("FAIL load_onehot: cyc=%0d load=%b, required at most one bit", cyc, lv);
    end
    checks++;
    if (bus.wr_busy !== (|lv)) begin
      failures++;
      $display("FAIL wr_busy: cyc=%0d got %b, required %b", cyc, bus.wr_busy, |lv);
    end

    if (bus.ack != 3'b000 || (ack_q.size() > 0 && ack_q[0].cyc <= cyc)) begin
      checks++;
      if (ack_q.size() == 0) begin
        failures++;
        $display("FAIL ack_unexpected: cyc=%0d got %b, required 000", cyc, bus.ack);
      end else if (ack_q[0].cyc > cyc) begin
        failures++;
        $display("FAIL ack_unexpected: cyc=%0d got %b, required 000", cyc, bus.ack);
      end else begin
        ea = ack_q.pop_front();
        if (ea.cyc != cyc || bus.ack !== ea.ack) begin
          failures++;
          $display("FAIL ack: cyc=%0d got %b, required %b at cyc %0d",
                   cyc, bus.ack, ea.ack, ea.cyc);
        end
      end
    end

    if (lv != 4'b0000 || (ld_q.size() > 0 && ld_q[0].cyc <= cyc)) begin
      checks++;
      if (ld_q.size() == 0) begin
        failures++;
        $display("FAIL load_unexpected: cyc=%0d got load=%b data=%h, required no load",
                 cyc, lv, bus.wr_data);
      end else if (ld_q[0].cyc > cyc) begin
        failures++;
        $display("FAIL load_unexpected: cyc=%0d got load=%b data=%h, required no load",
                 cyc, lv, bus.wr_data);
      end else begin
        el = ld_q.pop_front();
        if (el.cyc != cyc || lv !== el.load || bus.wr_data !== el.data) begin
          failures++;
          $display("FAIL load: cyc=%0d got load=%b data=%h, required load=%b data=%h at cyc %0d",
                   cyc, lv, bus.wr_data, el.load, el.data, el.cyc);
        end
      end
    end
  end

  // One cycle of stimulus; eload/edata describe the write expected in the following cycle.
  task automatic step(input logic r, input logic h, input logic [2:0] rq,
                      input logic [2:0] eack, input logic [3:0] eload, input logic [7:0] edata);
    @(posedge clk);
    #1;
    reset    = r;
    bus.hold = h;
    bus.req  = rq;
    if (eack != 3'b000) ack_q.push_back('{cyc: cyc, ack: eack});
    if (eload != 4'b0000) ld_q.push_back('{cyc: cyc + 1, load: eload, data: edata});
  endtask

  task automatic set_rq(input int i, input logic [1:0] d, input logic [7:0] v);
    case (i)
      0: begin bus.dest0 = d; bus.data0 = v; end
      1: begin bus.dest1 = d; bus.data1 = v; end
      default: begin bus.dest2 = d; bus.data2 = v; end
    endcase
  endtask

  task automatic check_idle_state(input string name);
    @(negedge clk);
    checks++;
    if (bus.wr_data !== 8'h00 || bus.wr_busy !== 1'b0 ||
        {bus.load3, bus.load2, bus.load1, bus.load0} !== 4'b0000) begin
      failures++;
      $display("FAIL %s: got wr_data=%h busy=%b load=%b, required 00/0/0000", name,
               bus.wr_data, bus.wr_busy, {bus.load3, bus.load2, bus.load1, bus.load0});
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.hold = 1'b0;
    bus.req  = 3'b000;
    set_rq(0, 2'd0, 8'h00);
    set_rq(1, 2'd0, 8'h00);
    set_rq(2, 2'd0, 8'h00);

    // Reset with all requesters active: no grant may appear.
    step(1'b1, 1'b0, 3'b111, 3'b000, 4'b0000, 8'h00);
    step(1'b1, 1'b0, 3'b111, 3'b000, 4'b0000, 8'h00);
    check_idle_state("reset_state");

    // Round-robin from ptr=0, each requester drops req after its ack.
    set_rq(0, 2'd0, 8'h11);
    set_rq(1, 2'd1, 8'h22);
    set_rq(2, 2'd2, 8'h33);
    step(1'b0, 1'b0, 3'b111, 3'b001, 4'b0001, 8'h11);
    step(1'b0, 1'b0, 3'b110, 3'b010, 4'b0010, 8'h22);
    step(1'b0, 1'b0, 3'b100, 3'b100, 4'b0100, 8'h33);

    // Move ptr to 1, then req=101 for four cycles with no write-stage bubble.
    set_rq(0, 2'd0, 8'h44);
    step(1'b0, 1'b0, 3'b001, 3'b001, 4'b0001, 8'h44);
    step(1'b0, 1'b0, 3'b101, 3'b100, 4'b0100, 8'h33);
    step(1'b0, 1'b0, 3'b101, 3'b001, 4'b0001, 8'h44);
    step(1'b0, 1'b0, 3'b101, 3'b100, 4'b0100, 8'h33);
    step(1'b0, 1'b0, 3'b101, 3'b001, 4'b0001, 8'h44);

    // Hold rises right after a capture: that write completes, then nothing for 3 cycles.
    set_rq(1, 2'd1, 8'h66);
    step(1'b0, 1'b1, 3'b010, 3'b000, 4'b0000, 8'h00);
    step(1'b0, 1'b1, 3'b010, 3'b000, 4'b0000, 8'h00);
    step(1'b0, 1'b1, 3'b010, 3'b000, 4'b0000, 8'h00);
    step(1'b0, 1'b0, 3'b010, 3'b010, 4'b0010, 8'h66);
    step(1'b0, 1'b0, 3'b000, 3'b000, 4'b0000, 8'h00);

    // ptr=2: two back-to-back writes to register 3.
    set_rq(0, 2'd3, 8'hA5);
    set_rq(1, 2'd3, 8'h5A);
    step(1'b0, 1'b0, 3'b011, 3'b001, 4'b1000, 8'hA5);
    step(1'b0, 1'b0, 3'b010, 3'b010, 4'b1000, 8'h5A);
    step(1'b0, 1'b0, 3'b000, 3'b000, 4'b0000, 8'h00);

    // Transfer, then reset the next cycle: the captured write is dropped.
    set_rq(1, 2'd1, 8'h77);
    step(1'b0, 1'b0, 3'b010, 3'b010, 4'b0000, 8'h00);
    step(1'b1, 1'b0, 3'b111, 3'b000, 4'b0000, 8'h00);
    set_rq(0, 2'd0, 8'h99);
    step(1'b0, 1'b0, 3'b111, 3'b001, 4'b0001, 8'h99);
    check_idle_state("post_reset_state");
    step(1'b0, 1'b0, 3'b000, 3'b000, 4'b0000, 8'h00);

    // Idle with req=000.
    step(1'b0, 1'b0, 3'b000, 3'b000, 4'b0000, 8'h00);
    step(1'b0, 1'b0, 3'b000, 3'b000, 4'b0000, 8'h00);
    @(negedge clk);
    @(negedge clk);

    checks++;
    if (ack_q.size() != 0) begin
      failures++;
      $display("FAIL ack_drain: got %0d pending grants, required 0", ack_q.size());
    end
    checks++;
    if (ld_q.size() != 0) begin
      failures++;
      $display("FAIL load_drain: got %0d pending writes, required 0", ld_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DW, default 8: data width of each requester and of the register-file write data.
REQ-002 Parameter NREQ, fixed at 3: number of write requesters (0=ALU, 1=MEM, 2=IO).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req  input  3  per-requester write request, bit i = requester i.
REQ-006 dest0, dest1, dest2  input  2 each  target register index (0..3) of requesters 0..2.
REQ-007 data0, data1, data2  input  DW each  write data of requesters 0..2.
REQ-008 ack  output  3  one-hot grant; bit i high = requester i's write is accepted this cycle.
REQ-009 hold  input  1  freeze: no new grants while high.
REQ-010 wr_data  output  DW  data driven to the register file write input.
REQ-011 load0, load1, load2, load3  output  1 each  register-file write enables.
REQ-012 wr_busy  output  1  write stage holds a valid write this cycle (OR of load0..3).

Function
REQ-013 ack SHALL be combinational from req, hold and the priority pointer, with at most one bit high.
REQ-014 A transfer on requester i SHALL occur in a cycle where req[i] and ack[i] are both high.
REQ-015 A requester SHALL keep req, dest and data stable until acked; the block SHALL not check this.
REQ-016 Arbitration SHALL be round-robin: search order starts at ptr, then ptr+1, ptr+2 (mod 3).
REQ-017 After a transfer by requester i, ptr SHALL become (i+1) mod 3; with no transfer, ptr SHALL be unchanged.
REQ-018 While hold is high, ack SHALL be 000 and ptr SHALL be unchanged.
REQ-019 On a transfer, the write stage SHALL register the winner's dest and data at the same clock edge.
REQ-020 One cycle after a transfer, exactly one loadN (N = registered dest) SHALL be high for one cycle, with wr_data = registered data.
REQ-021 Latency from transfer to loadN SHALL be exactly 1 cycle; throughput SHALL be one write per cycle.
REQ-022 In a cycle without a transfer, all of load0..3 SHALL be low in the following cycle; wr_data SHALL hold its last value.
REQ-023 At most one of load0..3 SHALL be high in any cycle, because the register file prioritises load0 > load1 > load2 > load3.
REQ-024 A write already captured when hold rises SHALL still complete in the next cycle.
REQ-025 Back-to-back writes to the same register SHALL both be issued, in grant order, so the last one wins.
REQ-026 With req = 000, ack SHALL be 000 and the block SHALL stay idle with no loadN.

Reset
REQ-027 When reset is high at a clock edge:
  - ptr SHALL be 0.
  - the write-stage valid SHALL be 0, so load0..3 and wr_busy are 0.
  - wr_data SHALL be 0.
REQ-028 ack SHALL be 000 while reset is high.
REQ-029 A write captured in the cycle before reset asserts SHALL be dropped, with no loadN after the reset edge.

Structure
REQ-030 NREQ and the requester index constants REQ_ALU=0, REQ_MEM=1 and REQ_IO=2 SHALL live in the shared defines file.
REQ-031 The round-robin pick-and-pointer logic SHALL be one sub-module, rr_arbiter3.
REQ-032 The write-stage register and the dest-to-load decoder SHALL live in regfile_wb_arbiter.

Verification
REQ-033 After reset:
  - stimulus: req=111, dest0=0/data0=8'h11, dest1=1/data1=8'h22, dest2=2/data2=8'h33, each requester dropping its req after its ack.
  - required: ack 001, 010, 100 on consecutive cycles.
  - required: load0/8'h11, then load1/8'h22, then load2/8'h33 on the following cycles.
REQ-034 With ptr=1, req=101 held for 4 cycles:
  - required: ack sequence 100, 001, 100, 001.
  - required: no idle cycle on load0..3.
REQ-035 hold=1 for 3 cycles with req=010 pending:
  - required: ack=000 and no loadN during hold.
  - required: ack=010 in the first cycle after hold falls, and the matching loadN the cycle after.
REQ-036 Two consecutive grants to dest=3 (data 8'hA5, then 8'h5A):
  - required: load3 high for 2 cycles.
  - required: wr_data 8'hA5, then 8'h5A.
REQ-037 reset asserted one cycle after a transfer:
  - required: no loadN after the reset edge.
  - required: ptr=0, so the next req=111 gives ack=001.
REQ-038 Every scenario SHALL assert that load0..3 are never more than one-hot and ack is never more than one-hot.
